// File: rtl/rr_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_pkg
// Description : Shared sizing helpers, default parameters and grant functions
//               for the round-robin multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_pkg;

   localparam int c_default_n_ch = 4;
   localparam int c_default_w    = 8;

   // Select width; never below 1 so a port of width zero cannot appear.
   function automatic int sel_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Rotate-and-find-first over up to 16 requests. Search starts at ptr+1 and
   // wraps at n, so passing ptr = n-1 yields plain lowest-index priority.
   function automatic logic [15:0] rr_grant(input logic [15:0] req,
                                            input logic [3:0]  ptr,
                                            input int          n);
      logic [15:0] grant;
      logic        found;
      int          idx;
      grant = '0;
      found = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         idx = (int'(ptr) + k) % n;
         if (k <= n && !found && req[idx[3:0]]) begin
            grant[idx[3:0]] = 1'b1;
            found           = 1'b1;
         end
      end
      return grant;
   endfunction

   function automatic logic [3:0] onehot_idx(input logic [15:0] onehot);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (onehot[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : One-hot request arbiter with a last-grant pointer. Defining
//               RR_MUX_FIXED_PRIO_EN removes the pointer (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int N_CH  = c_default_n_ch,
   parameter int SEL_W = sel_w(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] req,
   input  logic            advance,
   output logic [N_CH-1:0] grant
);

   logic [15:0] w_req_ext;
   logic [15:0] w_grant_ext;

   assign w_req_ext = 16'(req);
   assign grant     = w_grant_ext[N_CH-1:0];

`ifdef RR_MUX_FIXED_PRIO_EN
   logic w_unused;

   assign w_grant_ext = rr_grant(w_req_ext, 4'(N_CH - 1), N_CH);
   assign w_unused    = ^{clk, rst_n, advance};
`else
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_grant_idx;

   assign w_grant_ext = rr_grant(w_req_ext, 4'(r_ptr), N_CH);
   assign w_grant_idx = SEL_W'(onehot_idx(w_grant_ext));

   // Reset parks the pointer on the last channel so channel 0 is searched first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= SEL_W'(N_CH - 1);
      end else if (advance) begin
         r_ptr <= w_grant_idx;
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/rr_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux
// Description : N-channel arbitrated multiplexer with a single registered
//               output stage. Build option RR_MUX_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux
   import rr_mux_pkg::*;
#(
   parameter  int N_CH  = c_default_n_ch,
   parameter  int W     = c_default_w,
   localparam int SEL_W = sel_w(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  in_valid,
   input  logic [W-1:0]     in_data [N_CH],
   output logic [N_CH-1:0]  in_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_sel,
   input  logic             out_ready
);

   logic             r_out_valid;
   logic [W-1:0]     r_out_data;
   logic [SEL_W-1:0] r_out_sel;

   logic [N_CH-1:0]  w_grant;
   logic [SEL_W-1:0] w_grant_idx;
   logic             w_load_en;
   logic             w_xfer;

   rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_arbiter (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (in_valid),
      .advance (w_xfer),
      .grant   (w_grant)
   );

   // The register may load when empty or draining; reset blocks all accepts.
   assign w_load_en   = !r_out_valid || out_ready;
   assign in_ready    = (rst_n && w_load_en) ? w_grant : '0;
   assign w_xfer      = |in_ready;
   assign w_grant_idx = SEL_W'(onehot_idx(16'(w_grant)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= in_data[w_grant_idx];
         r_out_sel   <= w_grant_idx;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux
// Description : Self-checking bench for rr_mux: directed scenarios followed by
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux;

   localparam int N_CH  = 4;
   localparam int W     = 8;
   localparam int SEL_W = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N_CH-1:0] in_valid;
   logic [W-1:0]    in_data [N_CH];
   logic [N_CH-1:0] in_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [SEL_W-1:0] out_sel;
   logic            out_ready;

   always #5 clk = ~clk;

   rr_mux #(.N_CH(N_CH), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   int n_pass   = 0;
   int n_checks = 0;

   // Reference model: last granted channel and the beat sitting in the output.
   int           m_last = N_CH - 1;
   bit           m_valid = 1'b0;
   logic [W-1:0] m_data = '0;
   int           m_sel = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic int pick(input logic [N_CH-1:0] v);
      int start;
`ifdef RR_MUX_FIXED_PRIO_EN
      start = 0;
`else
      start = (m_last + 1) % N_CH;
`endif
      for (int k = 0; k < N_CH; k++) begin
         if (v[(start + k) % N_CH]) return (start + k) % N_CH;
      end
      return -1;
   endfunction

   // Inputs are set just after a rising edge; this checks accepts, clocks,
   // advances the model and checks the registered outputs.
   task automatic cycle();
      int              g;
      logic [N_CH-1:0] exp_rdy;
      bit              xfer;
      #2;
      g       = pick(in_valid);
      exp_rdy = '0;
      xfer    = rst_n && !(m_valid && !out_ready) && (g >= 0);
      if (xfer) exp_rdy[g] = 1'b1;
      check("in_ready", in_ready, exp_rdy);
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_sel   = 0;
         m_last  = N_CH - 1;
      end else if (xfer) begin
         m_valid = 1'b1;
         m_data  = in_data[g];
         m_sel   = g;
         m_last  = g;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      check("out_valid", out_valid, m_valid);
      check("out_data", out_data, m_data);
      check("out_sel", out_sel, m_sel);
   endtask

   initial begin
      int seq [4];
      seq = '{1, 2, 3, 0};
      rst_n     = 1'b0;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      for (int i = 0; i < N_CH; i++) in_data[i] = 8'hA0 + 8'(i);
      @(posedge clk);
      #1;

      // Reset with every channel requesting.
      cycle();
      cycle();
      check("rst_in_ready", in_ready, 4'b0000);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);

      rst_n = 1'b1;
      cycle();
      check("first_sel", out_sel, 0);
      check("first_data", out_data, 8'hA0);

`ifndef RR_MUX_FIXED_PRIO_EN
      // Full rotation with continuous drain.
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("rot_sel", out_sel, seq[i]);
         check("rot_data", out_data, 8'hA0 + 8'(seq[i]));
      end

      // Backpressure for three cycles, then release.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("hold_sel", out_sel, 0);
         check("hold_rdy", in_ready, 4'b0000);
      end
      out_ready = 1'b1;
      cycle();
      check("release_sel", out_sel, 1);

      // Lone channel 2, then channels 1 and 3 compete.
      in_valid = 4'b0100;
      cycle();
      check("ch2_sel", out_sel, 2);
      in_valid = 4'b1010;
      cycle();
      check("after2_sel", out_sel, 3);
      cycle();
      check("after3_sel", out_sel, 1);

      // Reset while holding a beat from channel 2.
      in_valid = 4'b0100;
      cycle();
      check("pre_rst_valid", out_valid, 1'b1);
      rst_n    = 1'b0;
      in_valid = 4'b1001;
      cycle();
      check("mid_rst_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      cycle();
      check("post_rst_sel", out_sel, 0);
`else
      // Lowest index always wins while channels 1 and 3 request.
      in_valid = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("fixed_sel", out_sel, 1);
      end
`endif

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         rst_n     = ($urandom_range(0, 39) != 0);
         in_valid  = N_CH'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N_CH; i++) in_data[i] = W'($urandom);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
